// File: rtl/sdram_init_seq.sv
// SDR SDRAM power-up sequencer: wait, PRECHARGE ALL, AUTO REFRESH burst, LOAD MODE.
// Define SDRAM_INIT_REF_REQ_EN to add the post-init periodic refresh request handshake.
module sdram_init_seq #(
  parameter int          POWER_UP_CYC = 10000,
  parameter int          T_RP         = 2,
  parameter int          T_RFC        = 7,
  parameter int          T_MRD        = 2,
  parameter int          AREF_NUM     = 8,
  parameter logic [11:0] MODE_REG     = 12'h032
`ifdef SDRAM_INIT_REF_REQ_EN
  ,
  parameter int          REF_INTERVAL = 750
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [17:0] cmd,
  output logic        init_done
`ifdef SDRAM_INIT_REF_REQ_EN
  ,
  output logic        ref_req,
  input  logic        ref_ack
`endif
);

  localparam int MAX_A    = (POWER_UP_CYC > T_RP) ? POWER_UP_CYC : T_RP;
  localparam int MAX_B    = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int AREF_W   = $clog2(AREF_NUM + 1);

  // Wait states exit on the last count so a command at n with wait T lands the next at n+T+1.
  localparam logic [CNT_W-1:0]  PWR_LAST  = CNT_W'(POWER_UP_CYC);
  localparam logic [CNT_W-1:0]  RP_LAST   = CNT_W'((T_RP  > 0) ? T_RP  - 1 : 0);
  localparam logic [CNT_W-1:0]  RFC_LAST  = CNT_W'((T_RFC > 0) ? T_RFC - 1 : 0);
  localparam logic [CNT_W-1:0]  MRD_LAST  = CNT_W'((T_MRD > 0) ? T_MRD - 1 : 0);
  localparam logic [AREF_W-1:0] AREF_LAST = AREF_W'(AREF_NUM);

  localparam logic [17:0] CMD_NOP  = {4'b0111, 2'b00, 12'h000};
  localparam logic [17:0] CMD_PRE  = {4'b0010, 2'b00, 12'h400};
  localparam logic [17:0] CMD_AREF = {4'b0001, 2'b00, 12'h000};
  localparam logic [17:0] CMD_LMR  = {4'b0000, 2'b00, MODE_REG};

  typedef enum logic [2:0] {
    S_WAIT_PWR,
    S_PRE,
    S_WAIT_RP,
    S_AREF,
    S_WAIT_RFC,
    S_LMR,
    S_WAIT_MRD,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   wait_cnt;
  logic [AREF_W-1:0]  aref_cnt;
  logic               more_aref;

  function automatic logic [17:0] cmd_of(input state_t s);
    case (s)
      S_PRE:   return CMD_PRE;
      S_AREF:  return CMD_AREF;
      S_LMR:   return CMD_LMR;
      default: return CMD_NOP;
    endcase
  endfunction

  // aref_cnt already includes the AREF currently on the bus.
  assign more_aref = (aref_cnt < AREF_LAST);

  always_comb begin
    state_next = state;
    unique case (state)
      S_WAIT_PWR: if (wait_cnt == PWR_LAST) state_next = S_PRE;
      S_PRE:      state_next = (T_RP == 0) ? S_AREF : S_WAIT_RP;
      S_WAIT_RP:  if (wait_cnt == RP_LAST) state_next = S_AREF;
      S_AREF: begin
        if (T_RFC != 0)     state_next = S_WAIT_RFC;
        else if (more_aref) state_next = S_AREF;
        else                state_next = S_LMR;
      end
      S_WAIT_RFC: if (wait_cnt == RFC_LAST) state_next = more_aref ? S_AREF : S_LMR;
      S_LMR:      state_next = (T_MRD == 0) ? S_DONE : S_WAIT_MRD;
      S_WAIT_MRD: if (wait_cnt == MRD_LAST) state_next = S_DONE;
      S_DONE:     state_next = S_DONE;
      default:    state_next = S_WAIT_PWR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_WAIT_PWR;
      wait_cnt  <= '0;
      aref_cnt  <= '0;
      cmd       <= CMD_NOP;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      cmd       <= cmd_of(state_next);
      init_done <= (state_next == S_DONE);
      if (state_next != state || state == S_DONE) wait_cnt <= '0;
      else                                        wait_cnt <= wait_cnt + CNT_W'(1);
      // Each AREF is a single cycle, so every entry into S_AREF is a new command.
      if (state_next == S_AREF) aref_cnt <= aref_cnt + AREF_W'(1);
    end
  end

`ifdef SDRAM_INIT_REF_REQ_EN
  localparam int              RI_W    = (REF_INTERVAL < 1) ? 1 : $clog2(REF_INTERVAL + 1);
  localparam logic [RI_W-1:0] RI_LAST = RI_W'((REF_INTERVAL > 0) ? REF_INTERVAL - 1 : 0);

  logic [RI_W-1:0] ref_cnt;

  // Interval counter is frozen while a request is outstanding, so requests never queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
      ref_req <= 1'b0;
    end else if (ref_req) begin
      if (ref_ack) begin
        ref_req <= 1'b0;
        ref_cnt <= '0;
      end
    end else if (init_done) begin
      if (ref_cnt == RI_LAST) begin
        ref_req <= 1'b1;
        ref_cnt <= '0;
      end else begin
        ref_cnt <= ref_cnt + RI_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: three instances (default, zero-wait, small timings) checked
// every cycle against a schedule computed from the command timing rules.
module tb_sdram_init_seq;

  localparam logic [17:0] NOP = 18'h1C000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic [17:0] cmd_a, cmd_b, cmd_c;
  logic done_a, done_b, done_c;
  logic fin_a = 1'b0, fin_b = 1'b0, fin_c = 1'b0;
`ifdef SDRAM_INIT_REF_REQ_EN
  logic req_a, req_b, req_c;
  logic ack_c = 1'b1;
  logic exp_req = 1'b0;
  int   next_rise = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Schedule: PRE at pwr, AREFs every rfc+1 from pwr+rp+1, LMR right after the last AREF window.
  function automatic logic [17:0] exp_cmd(input int c, input int pwr, input int rp, input int rfc,
                                          input int n, input logic [11:0] mode);
    int first_aref;
    int t_lmr;
    first_aref = pwr + rp + 1;
    t_lmr      = first_aref + n * (rfc + 1);
    if (c == pwr) return 18'h08400;
    if (c >= first_aref && c < t_lmr && ((c - first_aref) % (rfc + 1)) == 0) return 18'h04000;
    if (c == t_lmr) return {6'b000000, mode};
    return NOP;
  endfunction

  function automatic int done_at(input int pwr, input int rp, input int rfc, input int mrd,
                                 input int n);
    return pwr + rp + 1 + n * (rfc + 1) + mrd + 1;
  endfunction

  sdram_init_seq u_a (
    .clk(clk), .rst_n(rst_a), .cmd(cmd_a), .init_done(done_a)
`ifdef SDRAM_INIT_REF_REQ_EN
    , .ref_req(req_a), .ref_ack(1'b0)
`endif
  );

  sdram_init_seq #(
    .POWER_UP_CYC(20), .T_RP(0), .T_RFC(0), .T_MRD(0), .AREF_NUM(2)
  ) u_b (
    .clk(clk), .rst_n(rst_b), .cmd(cmd_b), .init_done(done_b)
`ifdef SDRAM_INIT_REF_REQ_EN
    , .ref_req(req_b), .ref_ack(1'b0)
`endif
  );

  sdram_init_seq #(
    .POWER_UP_CYC(30), .T_RP(1), .T_RFC(3), .T_MRD(2), .AREF_NUM(3), .MODE_REG(12'h2A5)
`ifdef SDRAM_INIT_REF_REQ_EN
    , .REF_INTERVAL(10)
`endif
  ) u_c (
    .clk(clk), .rst_n(rst_c), .cmd(cmd_c), .init_done(done_c)
`ifdef SDRAM_INIT_REF_REQ_EN
    , .ref_req(req_c), .ref_ack(ack_c)
`endif
  );

  int cyc_a = -1, cyc_b = -1, cyc_c = -1;
  always @(posedge clk or negedge rst_a) if (!rst_a) cyc_a <= -1; else cyc_a <= cyc_a + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) cyc_b <= -1; else cyc_b <= cyc_b + 1;
  always @(posedge clk or negedge rst_c) if (!rst_c) cyc_c <= -1; else cyc_c <= cyc_c + 1;

  always @(negedge clk) begin
    check("a_cmd",  cmd_a,  exp_cmd(cyc_a, 10000, 2, 7, 8, 12'h032));
    check("a_done", done_a, cyc_a >= done_at(10000, 2, 7, 2, 8));
    check("b_cmd",  cmd_b,  exp_cmd(cyc_b, 20, 0, 0, 2, 12'h032));
    check("b_done", done_b, cyc_b >= done_at(20, 0, 0, 0, 2));
    check("c_cmd",  cmd_c,  exp_cmd(cyc_c, 30, 1, 3, 3, 12'h2A5));
    check("c_done", done_c, cyc_c >= done_at(30, 1, 3, 2, 3));
`ifdef SDRAM_INIT_REF_REQ_EN
    // ack_c here is the value the DUT sampled on this cycle's rising edge.
    if (cyc_c < 0) begin
      exp_req   = 1'b0;
      next_rise = done_at(30, 1, 3, 2, 3) + 10;
    end else if (exp_req && ack_c) begin
      exp_req   = 1'b0;
      next_rise = cyc_c + 10;
    end else if (!exp_req && cyc_c == next_rise) begin
      exp_req = 1'b1;
    end
    check("c_ref_req", req_c, exp_req);
`endif
  end

  initial begin
    int hold;
    int stop_at;
    repeat (3) @(posedge clk);
    #2 rst_a = 1'b1;
    while (cyc_a < 10030) @(negedge clk);
    #2 rst_a = 1'b0;
    #1 check("a_async_cmd", cmd_a, NOP);
    check("a_async_done", done_a, 1'b0);
    hold = $urandom_range(1, 4);
    repeat (hold) @(posedge clk);
    #2 rst_a = 1'b1;
    stop_at = 10075 + $urandom_range(0, 20);
    while (cyc_a < stop_at) @(negedge clk);
    #2 rst_a = 1'b0;
    #1 check("a_async_done_clr", done_a, 1'b0);
    check("a_async_cmd2", cmd_a, NOP);
    fin_a = 1'b1;
  end

  initial begin
    int hold;
    int stop_at;
    for (int i = 0; i < 15; i++) begin
      hold = $urandom_range(1, 3);
      repeat (hold) @(posedge clk);
      #2 rst_b = 1'b1;
      stop_at = $urandom_range(15, 28);
      while (cyc_b < stop_at) @(negedge clk);
      #2 rst_b = 1'b0;
      #1 check("b_async_cmd", cmd_b, NOP);
      check("b_async_done", done_b, 1'b0);
    end
    @(posedge clk);
    #2 rst_b = 1'b1;
    while (cyc_b < 40) @(negedge clk);
    fin_b = 1'b1;
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_c = 1'b1;
    while (cyc_c < 120) @(negedge clk);
    while (cyc_c < 400) begin
      @(negedge clk);
`ifdef SDRAM_INIT_REF_REQ_EN
      #1 ack_c = ($urandom_range(0, 5) == 0);
`endif
    end
    fin_c = 1'b1;
  end

  initial begin
    for (int i = 0; i < 40000 && !(fin_a && fin_b && fin_c); i++) @(negedge clk);
    check("all_finished", {29'd0, fin_a, fin_b, fin_c}, 32'd7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
